// File: rtl/wb_commit_pkg.sv
// Shared constants for the writeback/commit stage: LoongArch exception codes,
// exception-vector bit positions and the commit FSM state encoding.
package wb_commit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } wb_state_e;

    localparam int EXCP_INT   = 0;
    localparam int EXCP_ADEF  = 1;
    localparam int EXCP_ITLBR = 2;
    localparam int EXCP_PIF   = 3;
    localparam int EXCP_IPPI  = 4;
    localparam int EXCP_SYS   = 5;
    localparam int EXCP_BRK   = 6;
    localparam int EXCP_INE   = 7;
    localparam int EXCP_IPE   = 8;
    localparam int EXCP_ALE   = 9;
    localparam int EXCP_RSVD  = 10;
    localparam int EXCP_DTLBR = 11;
    localparam int EXCP_PME   = 12;
    localparam int EXCP_DPPI  = 13;
    localparam int EXCP_PIS   = 14;
    localparam int EXCP_PIL   = 15;
    localparam int EXCP_NBITS = 16;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUBCODE_NONE = 9'h000;

    function automatic logic [5:0] excp_ecode(input int idx);
        logic [5:0] code;
        case (idx)
            EXCP_ADEF:              code = ECODE_ADE;
            EXCP_ITLBR, EXCP_DTLBR: code = ECODE_TLBR;
            EXCP_PIF:               code = ECODE_PIF;
            EXCP_IPPI, EXCP_DPPI:   code = ECODE_PPI;
            EXCP_SYS:               code = ECODE_SYS;
            EXCP_BRK:               code = ECODE_BRK;
            EXCP_INE:               code = ECODE_INE;
            EXCP_IPE:               code = ECODE_IPE;
            EXCP_ALE:               code = ECODE_ALE;
            EXCP_PME:               code = ECODE_PME;
            EXCP_PIS:               code = ECODE_PIS;
            EXCP_PIL:               code = ECODE_PIL;
            default:                code = ECODE_INT;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/wb_commit_excp_prio_enc.sv
// Combinational exception-vector priority encoder: lowest set bit wins and maps
// to {ecode, esubcode}; the reserved bit never selects a code.
module excp_prio_enc
    import wb_commit_pkg::*;
#(
    parameter int EXCP_W = 16
) (
    input  logic [EXCP_W-1:0] excp_i,
    output logic [5:0]        ecode_o,
    output logic [8:0]        esubcode_o
);

    localparam int NB = (EXCP_W < EXCP_NBITS) ? EXCP_W : EXCP_NBITS;

    // Scan high to low so the last (lowest) hit overwrites earlier ones.
    always_comb begin
        ecode_o    = ECODE_INT;
        esubcode_o = ESUBCODE_NONE;
        for (int i = NB - 1; i >= 0; i--) begin
            if (i != EXCP_RSVD && excp_i[i]) begin
                ecode_o    = excp_ecode(i);
                esubcode_o = ESUBCODE_NONE;
            end
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Registered writeback/commit stage: holds one instruction, commits it to the
// register file, raises exception/ertn flushes and counts retirements. WB_SOFT_INT_EN adds soft_int.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int EXCP_W = 16,
    parameter int CSR_W  = 47,
    parameter int CNT_W  = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       left_valid,
    output logic                       left_ready,
    input  logic                       commit_stall,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_inst,
    input  logic [DATA_W-1:0]          in_result,
    input  logic [REG_AW-1:0]          in_wreg_idx,
    input  logic                       in_wreg_en,
    input  logic                       in_inst_valid,
    input  logic                       in_break,
    input  logic [EXCP_W-1:0]          in_excp,
    input  logic                       in_ertn,
    input  logic [CSR_W-1:0]           in_csr,
`ifdef WB_SOFT_INT_EN
    input  logic                       soft_int,
`endif
    output logic                       rf_we,
    output logic [REG_AW-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [DATA_W+REG_AW:0]     wb_bypass,
    output logic [CSR_W-1:0]           wb_csr,
    output logic                       excp_flush,
    output logic                       ertn_flush,
    output logic [5:0]                 ecode,
    output logic [8:0]                 esubcode,
    output logic [DATA_W-1:0]          excp_era,
    output logic                       retire_valid,
    output logic [DATA_W-1:0]          retire_pc,
    output logic [DATA_W-1:0]          retire_inst,
    output logic                       retire_break,
    output logic [CNT_W-1:0]           instret,
    output logic [1:0]                 dbg_state
);

    localparam int NB = (EXCP_W < EXCP_NBITS) ? EXCP_W : EXCP_NBITS;

    wb_state_e          state_q, state_d;
    logic [DATA_W-1:0]  pc_q, inst_q, result_q;
    logic [REG_AW-1:0]  widx_q;
    logic               wen_q, ivalid_q, break_q, ertn_q;
    logic [NB-1:0]      excp_q;
    logic [CSR_W-1:0]   csr_q;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               load;
    logic               soft_int_w;
    logic               excp_any;
    logic               commit;
    logic [5:0]         enc_ecode;
    logic [8:0]         enc_esubcode;

    generate
        if (EXCP_W > NB) begin : g_excp_hi
            logic unused_excp_hi;
            assign unused_excp_hi = ^in_excp[EXCP_W-1:NB];
        end
    endgenerate

`ifdef WB_SOFT_INT_EN
    assign soft_int_w = soft_int;
`else
    assign soft_int_w = 1'b0;
`endif

    excp_prio_enc #(.EXCP_W(NB)) u_enc (
        .excp_i     (excp_q),
        .ecode_o    (enc_ecode),
        .esubcode_o (enc_esubcode)
    );

    // Reset gates commit so an instruction held across reset never retires.
    assign excp_any = (|excp_q) | soft_int_w;
    assign commit   = reset && (state_q == ST_FULL) && !commit_stall;

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        left_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                left_ready = 1'b1;
                if (left_valid) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!commit_stall) begin
                    if (excp_any || ertn_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        left_ready = 1'b1;
                        if (left_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                left_ready = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        left_ready = left_ready & reset;
        instret_d  = instret_q;
        if (commit && !excp_any) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            result_q  <= '0;
            widx_q    <= '0;
            wen_q     <= 1'b0;
            ivalid_q  <= 1'b0;
            break_q   <= 1'b0;
            ertn_q    <= 1'b0;
            excp_q    <= '0;
            csr_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            if (load) begin
                pc_q     <= in_pc;
                inst_q   <= in_inst;
                result_q <= in_result;
                widx_q   <= in_wreg_idx;
                wen_q    <= in_wreg_en;
                ivalid_q <= in_inst_valid;
                break_q  <= in_break;
                ertn_q   <= in_ertn;
                excp_q   <= in_excp[NB-1:0];
                csr_q    <= in_csr;
            end
        end
    end

    assign rf_we        = commit && !excp_any && wen_q && ivalid_q;
    assign rf_waddr     = widx_q;
    assign rf_wdata     = result_q;
    assign wb_bypass    = {result_q, widx_q,
                           wen_q && reset && (state_q == ST_FULL) && !excp_any};
    assign wb_csr       = {csr_q[CSR_W-1] && commit && !excp_any, csr_q[CSR_W-2:0]};
    assign excp_flush   = commit && excp_any;
    assign ertn_flush   = commit && !excp_any && ertn_q;
    assign ecode        = soft_int_w ? ECODE_INT : enc_ecode;
    assign esubcode     = soft_int_w ? ESUBCODE_NONE : enc_esubcode;
    assign excp_era     = pc_q;
    assign retire_valid = commit && !excp_any;
    assign retire_pc    = pc_q;
    assign retire_inst  = inst_q;
    assign retire_break = commit && !excp_any && break_q;
    assign instret      = instret_q;
    assign dbg_state    = state_q;

endmodule
